// File: rtl/multiply_add_pipe_if.sv
// Operation/result handshake bundle for multiply_add_pipe.
// The master side issues operations and consumes results; the slave side is the pipeline.
interface multiply_add_pipe_if #(
    parameter int unsigned BITS = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     a;
    logic [BITS-1:0]     b;
    logic [2*BITS-1:0]   c;
    logic                is_signed;
    logic                negate;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [2*BITS-1:0]   o;
    logic                busy;

    modport master (
        output in_valid, a, b, c, is_signed, negate, flush, out_ready,
        input  in_ready, out_valid, o, busy
    );

    modport slave (
        input  in_valid, a, b, c, is_signed, negate, flush, out_ready,
        output in_ready, out_valid, o, busy
    );
endinterface

// File: rtl/multiply_add_pipe.sv
// Pipelined c +/- a*b with valid/ready flow control, flush and async reset.
// Stage 0 holds the product (plus addend/mode); stage 1 folds in the addend; later stages delay.
module multiply_add_pipe #(
    parameter int unsigned BITS    = 64,
    parameter int unsigned LATENCY = 3
) (
    input logic               clk,
    input logic               rst,
    multiply_add_pipe_if.slave bus
);
    localparam int unsigned W = 2 * BITS;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("multiply_add_pipe: LATENCY must be in 1..8");
    end

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [W-1:0]       data_q [LATENCY];
    logic [W-1:0]       data_d [LATENCY];
    logic [W-1:0]       c0_q, c0_d;
    logic               neg0_q, neg0_d;

    logic               adv;
    logic [W-1:0]       a_ext, b_ext, prod;

    function automatic logic [W-1:0] fold(input logic [W-1:0] cc, input logic [W-1:0] pp,
                                          input logic nn);
        return nn ? cc - pp : cc + pp;
    endfunction

    always_comb begin
        adv   = !vld_q[LATENCY-1] | bus.out_ready;
        a_ext = bus.is_signed ? {{BITS{bus.a[BITS-1]}}, bus.a} : {{BITS{1'b0}}, bus.a};
        b_ext = bus.is_signed ? {{BITS{bus.b[BITS-1]}}, bus.b} : {{BITS{1'b0}}, bus.b};
        prod  = a_ext * b_ext;

        vld_d  = vld_q;
        c0_d   = c0_q;
        neg0_d = neg0_q;
        for (int i = 0; i < int'(LATENCY); i++) data_d[i] = data_q[i];

        // Flush beats both the shift and any same-cycle operation; data only moves with a valid.
        if (bus.flush) begin
            vld_d = '0;
        end else if (adv) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = (LATENCY == 1) ? fold(bus.c, prod, bus.negate) : prod;
                c0_d      = bus.c;
                neg0_d    = bus.negate;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_d[i] = (i == 1) ? fold(c0_q, data_q[0], neg0_q) : data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            c0_q   <= '0;
            neg0_q <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) data_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            c0_q   <= c0_d;
            neg0_q <= neg0_d;
            for (int i = 0; i < int'(LATENCY); i++) data_q[i] <= data_d[i];
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.o         = data_q[LATENCY-1];
    assign bus.busy      = |vld_q;
endmodule

// File: doc/multiply_add_pipe.md
MULTIPLY_ADD_PIPE -- requirements
Module: multiply_add_pipe

Interface
REQ-001 Parameter BITS, default 64: operand width of a and b; addend and result width is 2*BITS.
REQ-002 Parameter LATENCY, default 3: pipeline depth in cycles; legal range 1..8; other values are an elaboration error.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input operation present this cycle.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 a  input  BITS  multiplicand.
REQ-008 b  input  BITS  multiplier.
REQ-009 c  input  2*BITS  addend.
REQ-010 is_signed  input  1  1: a and b are two's complement; 0: unsigned; sampled with the operation.
REQ-011 negate  input  1  1: result is c - a*b; 0: result is c + a*b; sampled with the operation.
REQ-012 flush  input  1  synchronous discard of all in-flight operations.
REQ-013 out_valid  output  1  o holds a completed result.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 o  output  2*BITS  result.
REQ-016 busy  output  1  at least one pipeline stage holds a valid operation.

Function
REQ-017 The block is a LATENCY-stage pipeline; each stage holds a valid bit and its data.
REQ-018 Advance condition: adv = !out_valid | out_ready; when adv is 1, all stages shift by one; when adv is 0, all stages hold.
REQ-019 in_ready equals adv and is combinational from out_ready and the last-stage valid bit.
REQ-020 An operation is accepted when in_valid & in_ready; its result appears with out_valid=1 exactly LATENCY cycles later if adv stays 1.
REQ-021 With continuous acceptance and out_ready=1, throughput is one result per cycle with no bubbles.
REQ-022 Each stall cycle (adv=0) delays every in-flight result by exactly one cycle; no result is lost, duplicated or reordered.
REQ-023 A stage receiving a bubble (in_valid=0 while adv=1) has its valid bit cleared; its data is don't-care except in the last stage.
REQ-024 Product: a and b are extended to 2*BITS (sign-extended if is_signed=1, zero-extended otherwise), then multiplied; only the low 2*BITS bits are kept.
REQ-025 Result = (c + product) or (c - product) modulo 2^(2*BITS); overflow wraps silently with no flag.
REQ-026 is_signed and negate travel with their operation; a mode change between consecutive operations affects only the later operation.
REQ-027 Internal partitioning of the arithmetic across stages is free, provided REQ-020 latency and REQ-025 results hold.
REQ-028 o holds its value while out_valid=1 and out_ready=0.
REQ-029 o updates only when the last stage loads a valid operation; it otherwise keeps its last value.
REQ-030 flush=1 clears all valid bits at the clock edge regardless of adv; an operation presented in the same cycle is discarded.
REQ-031 in_ready still follows REQ-019 during flush.
REQ-032 busy = OR of all stage valid bits, including the last stage.

Reset
REQ-033 While rst=1: out_valid=0, busy=0, o=0, all stage valid bits 0; the effect is asynchronous and does not wait for clk.
REQ-034 rst asserted mid-operation discards all in-flight operations.
REQ-035 The first operation accepted after rst deasserts completes after LATENCY cycles with no residue from before reset.
REQ-036 in_ready=1 during and immediately after reset, since out_valid=0.

Verification (BITS=64, LATENCY=3)
REQ-037 Basic: a=3, b=5, c=7, unsigned, negate=0, out_ready=1 -> out_valid=1 with o=22 exactly 3 cycles after acceptance.
REQ-038 Sign modes: a=0xFFFF_FFFF_FFFF_FFFF, b=2, c=0 -> with is_signed=1, o=0xFFFF..FFFE (128-bit); with is_signed=0, o=0x1_FFFF_FFFF_FFFF_FFFE; back-to-back issue -> results in order, one per cycle.
REQ-039 Negate and wrap: a=2, b=3, c=10, negate=1 -> o=4; a=1, b=1, c=0, negate=1 -> o=2^128-1.
REQ-040 Backpressure: issue 5 operations with out_ready=0 -> in_ready=0 once out_valid=1, o held stable; raise out_ready -> all 5 results delivered in order, none lost or duplicated.
REQ-041 Flush: 3 operations in flight, flush=1 for one cycle -> busy=0 next cycle and no out_valid; the next accepted operation returns correctly after 3 cycles.
REQ-042 Async reset: assert rst between clock edges with 2 operations in flight -> out_valid=0 and o=0 immediately, before the next edge; after release, a=4, b=4, c=1 -> o=17 at latency 3.
